xnor3_bist_ctrl: RTL
====================

XNOR3_BIST_CTRL -- requirements
Module: xnor3_bist_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: wait cycles per vector before dut_out is sampled.
REQ-002 SHALL have parameter STOP_ON_FAIL, default 0: 1 ends the run at the first mismatch.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level-sampled run request, accepted in IDLE or DONE.
REQ-006 abort  input  1  cancels a run and returns to IDLE.
REQ-007 dut_out  input  1  output of the 3-input XNOR gate under test.
REQ-008 a, b, c  output  1 each  registered gate inputs; a = vec[2], b = vec[1], c = vec[0].
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when fail_mask == 0.
REQ-012 fail_mask  output  8  bit v set when vector v mismatched.
REQ-013 err_count  output  4  number of mismatches, 0..8.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on start=1 and abort=0; on that edge vec=0, sub=0, fail_mask=0, err_count=0.
REQ-016 In RUN, each vector SHALL be held on a, b, c for exactly SETTLE+1 cycles, with sub counting 0..SETTLE.
REQ-017 Sampling: at the edge where sub==SETTLE, dut_out SHALL be compared with expected = ~(vec[2]^vec[1]^vec[0]).
REQ-018 On a mismatch at sampling, fail_mask[vec] SHALL be set and err_count SHALL increment on the same edge.
REQ-019 After sampling with vec<7 (and no stop), vec SHALL increment and sub SHALL reset to 0.
REQ-020 After sampling with vec==7, the FSM SHALL move to DONE; a full run is 8*(SETTLE+1) busy cycles.
REQ-021 With STOP_ON_FAIL=1, the first mismatch SHALL move the FSM to DONE on the sampling edge, leaving vec at the failing value.
REQ-022 In DONE, a, b, c SHALL hold the last vector, and fail_mask, err_count and pass SHALL stay stable.
REQ-023 DONE -> RUN on start=1 and abort=0, with the same initialisation as REQ-015.
REQ-024 DONE -> IDLE on abort=1.
REQ-025 abort=1 in RUN SHALL go to IDLE on the next edge, zeroing a, b, c, fail_mask and err_count.
REQ-026 When abort and start are high together, abort SHALL win in every state.
REQ-027 start in RUN SHALL be ignored; no restart and no extension of the run.
REQ-028 dut_out SHALL be ignored except at sampling edges.
REQ-029 err_count SHALL saturate at 8 and SHALL never wrap.
REQ-030 pass SHALL be 0 outside DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, vec=0, sub=0, a=b=c=0, busy=0, done=0, pass=0, fail_mask=0 and err_count=0, regardless of the clock.
REQ-032 Reset asserted mid-run SHALL discard all partial results; the first start after reset release begins at vector 0.

Verification
REQ-033 Good XNOR model, SETTLE=1, one-cycle start pulse -> busy for 16 cycles, a,b,c steps 000..111 every 2 cycles, then done=1, pass=1, fail_mask=8'h00, err_count=0.
REQ-034 dut_out stuck at 0, SETTLE=1 -> done=1, pass=0, fail_mask=8'h69, err_count=4.
REQ-035 dut_out stuck at 1, SETTLE=3 -> 32 busy cycles, fail_mask=8'h96, err_count=4.
REQ-036 STOP_ON_FAIL=1, dut_out stuck at 0, SETTLE=1 -> DONE after 2 busy cycles with a,b,c=000, fail_mask=8'h01, err_count=1.
REQ-037 abort asserted while vec=3 -> IDLE next edge with outputs zeroed; a second start with abort and start both high -> stays in IDLE.
REQ-038 rst_n pulsed low between clock edges while vec=5 -> outputs zero before the next edge; a subsequent clean run -> pass=1.

Source files
------------

// File: rtl/xnor3_bist_ctrl.sv
// ----------------------------------------------------------------------------
// xnor3_bist_ctrl
//   Built-in self-test controller for a single 3-input XNOR gate. A run walks
//   the eight input vectors 000..111 onto a/b/c, holds each for SETTLE+1
//   cycles, samples dut_out on the last of those cycles and records every
//   mismatch in fail_mask / err_count.
//
// Parameters
//   SETTLE        wait cycles per vector before sampling (1..15)
//   STOP_ON_FAIL  1 = finish the run at the first mismatch
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      run request, accepted in IDLE or DONE
//   abort      cancel / return to IDLE (wins over start)
//   dut_out    output of the gate under test
//   a, b, c    registered gate inputs (vec[2], vec[1], vec[0])
//   busy       high while a run is in progress
//   done       high once a run has finished
//   pass       high in DONE when no vector mismatched
//   fail_mask  bit v set when vector v mismatched
//   err_count  number of mismatches (0..8)
// ----------------------------------------------------------------------------
module xnor3_bist_ctrl #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_mask,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     state;
    logic [2:0] vec;
    logic [3:0] sub;

    logic       mism;
    logic [7:0] mask_next;
    logic [3:0] err_next;

    // vec is itself a flop, so the gate inputs are registered outputs.
    assign a = vec[2];
    assign b = vec[1];
    assign c = vec[0];

    // Mismatch and the results as they would stand after this sampling edge.
    always_comb begin
        mism      = (dut_out != ~(vec[2] ^ vec[1] ^ vec[0]));
        mask_next = fail_mask;
        err_next  = err_count;
        if (mism) begin
            mask_next = fail_mask | (8'b1 << vec);
            if (err_count != 4'd8) begin
                err_next = err_count + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec       <= '0;
            sub       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= RUN;
                        vec       <= '0;
                        sub       <= '0;
                        fail_mask <= '0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end

                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        vec       <= '0;
                        sub       <= '0;
                        fail_mask <= '0;
                        err_count <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end else if (sub == SETTLE_L) begin
                        fail_mask <= mask_next;
                        err_count <= err_next;
                        // On an early stop vec is left on the failing vector.
                        if ((mism && STOP_ON_FAIL) || (vec == 3'd7)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (mask_next == '0);
                        end else begin
                            vec <= vec + 3'd1;
                            sub <= '0;
                        end
                    end else begin
                        sub <= sub + 4'd1;
                    end
                end

                DONE: begin
                    if (abort) begin
                        state     <= IDLE;
                        vec       <= '0;
                        sub       <= '0;
                        fail_mask <= '0;
                        err_count <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end else if (start) begin
                        state     <= RUN;
                        vec       <= '0;
                        sub       <= '0;
                        fail_mask <= '0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
